// File: rtl/alu_exec_pipe_pkg.sv
// Shared types for the ALU execution pipeline: micro-op encoding, per-stage
// register contents, default geometry and the ALU evaluation function.
package alu_exec_pipe_pkg;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSlt
  } alu_op_e;

  // res is produced by alu(); everything else travels through unchanged.
  typedef struct packed {
    alu_op_e     op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } micro_op_t;

  typedef struct packed {
    logic      valid;
    micro_op_t mop;
  } exec_stage_t;

  localparam int unsigned EXEC_STAGES_DEF    = 2;
  localparam int unsigned EXEC_ALU_STAGE_DEF = 1;

  function automatic micro_op_t alu(input micro_op_t mop);
    micro_op_t r;
    r = mop;
    unique case (mop.op)
      AluAdd:  r.res = mop.a + mop.b;
      AluSub:  r.res = mop.a - mop.b;
      AluAnd:  r.res = mop.a & mop.b;
      AluOr:   r.res = mop.a | mop.b;
      AluXor:  r.res = mop.a ^ mop.b;
      AluSll:  r.res = mop.a << mop.b[4:0];
      AluSrl:  r.res = mop.a >> mop.b[4:0];
      AluSlt:  r.res = {31'd0, ($signed(mop.a) < $signed(mop.b))};
      default: r.res = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_pipe_stage_reg.sv
// One pipeline stage register: reset/flushable valid bit, unreset payload,
// optional ALU application on load.
module alu_exec_pipe_stage_reg
  import alu_exec_pipe_pkg::*;
#(
  parameter bit APPLY_ALU = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  exec_stage_t d,
  output exec_stage_t q
);

  logic      valid_q;
  micro_op_t mop_q;
  micro_op_t mop_d;

  // Only evaluate the ALU for real ops so bubbles never toggle the datapath.
  always_comb begin
    mop_d = d.mop;
    if (APPLY_ALU && d.valid) begin
      mop_d = alu(d.mop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= d.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mop_q <= mop_d;
    end
  end

  assign q.valid = valid_q;
  assign q.mop   = mop_q;

endmodule

// File: rtl/alu_exec_pipe.sv
// Parametrised ALU execution pipe with valid/accept backpressure, bubble
// collapsing and flush. ALU_EXEC_PIPE_PERF_EN adds issue/stall counters.
module alu_exec_pipe
  import alu_exec_pipe_pkg::*;
#(
  parameter int STAGES    = EXEC_STAGES_DEF,
  parameter int ALU_STAGE = EXEC_ALU_STAGE_DEF,
  parameter int OCC_W     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_ready,
  input  micro_op_t        in_mop,
  output logic             busy,
  output logic             out_ready,
  output micro_op_t        out_mop,
  input  logic             out_accept,
`ifdef ALU_EXEC_PIPE_PERF_EN
  input  logic             perf_clr,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
`endif
  output logic [OCC_W-1:0] occupancy
);

  if (STAGES < 2 || ALU_STAGE < 1 || ALU_STAGE > STAGES - 1) begin : g_param_check
    $fatal(1, "alu_exec_pipe: illegal STAGES=%0d ALU_STAGE=%0d", STAGES, ALU_STAGE);
  end

  exec_stage_t       stage_d [STAGES];
  exec_stage_t       stage_q [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic              fire;
  logic              deliver;

  assign busy    = flush | ~adv[0];
  assign fire    = in_ready & ~busy;
  assign deliver = out_ready & out_accept;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_d[i] = '{valid: fire, mop: in_mop};
    end else begin : g_body
      assign stage_d[i] = stage_q[i-1];
    end

    alu_exec_pipe_stage_reg #(
      .APPLY_ALU (i == ALU_STAGE)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (adv[i]),
      .d     (stage_d[i]),
      .q     (stage_q[i])
    );

    assign valid[i] = stage_q[i].valid;
    // Flattened form of adv[i] = !valid[i] | adv[i+1]: a stage moves unless
    // it and every later stage are full while the output is stalled.
    assign adv[i] = out_accept | ~(&valid[STAGES-1:i]);
  end

  assign out_ready = valid[STAGES-1];
  assign out_mop   = stage_q[STAGES-1].mop;

  // Ops only enter at stage 0 and leave at the tail, so tracking the
  // handshakes keeps the count equal to popcount(valid) after every edge.
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(fire) - OCC_W'(deliver);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef ALU_EXEC_PIPE_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else if (perf_clr) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (fire) begin
        issued_q <= issued_q + 32'd1;
      end
      if (in_ready & busy & ~flush) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe (STAGES=4, ALU_STAGE=2); the perf
// counter section is built only with ALU_EXEC_PIPE_PERF_EN.
module tb_alu_exec_pipe;
  import alu_exec_pipe_pkg::*;

  localparam int STAGES    = 4;
  localparam int ALU_STAGE = 2;
  localparam int OCC_W     = $clog2(STAGES + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_ready;
  micro_op_t        in_mop;
  logic             busy;
  logic             out_ready;
  micro_op_t        out_mop;
  logic             out_accept;
  logic [OCC_W-1:0] occupancy;
`ifdef ALU_EXEC_PIPE_PERF_EN
  logic             perf_clr;
  logic [31:0]      perf_issued;
  logic [31:0]      perf_stall;
`endif

  always #5 clk = ~clk;

  alu_exec_pipe #(
    .STAGES    (STAGES),
    .ALU_STAGE (ALU_STAGE),
    .OCC_W     (OCC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_ready   (in_ready),
    .in_mop     (in_mop),
    .busy       (busy),
    .out_ready  (out_ready),
    .out_mop    (out_mop),
    .out_accept (out_accept),
`ifdef ALU_EXEC_PIPE_PERF_EN
    .perf_clr    (perf_clr),
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .occupancy  (occupancy)
  );

  int checks = 0;
  int errors = 0;

  alu_op_e     v_op  [8];
  logic [31:0] v_a   [8];
  logic [31:0] v_b   [8];
  logic [31:0] v_res [8];

  function automatic micro_op_t mk(input int i);
    micro_op_t m;
    m.op  = v_op[i];
    m.rd  = 5'(i + 1);
    m.a   = v_a[i];
    m.b   = v_b[i];
    m.res = '0;
    return m;
  endfunction

  function automatic logic [63:0] exp_of(input int i);
    return {27'd0, 5'(i + 1), v_res[i]};
  endfunction

  function automatic logic [63:0] got_of(input micro_op_t m);
    return {27'd0, m.rd, m.res};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first_k;
    int  got;
    int  seen;
    int  busy_seen;
    int  idx;
    bit  fired;

    // Hand-computed ALU vectors; rd = index+1 tags each op for ordering.
    v_op[0] = AluAdd; v_a[0] = 32'd5;          v_b[0] = 32'd7;          v_res[0] = 32'd12;
    v_op[1] = AluSub; v_a[1] = 32'd10;         v_b[1] = 32'd3;          v_res[1] = 32'd7;
    v_op[2] = AluAnd; v_a[2] = 32'h0000_F0F0;  v_b[2] = 32'h0000_FF00;  v_res[2] = 32'h0000_F000;
    v_op[3] = AluOr;  v_a[3] = 32'h0000_0F00;  v_b[3] = 32'h0000_00F0;  v_res[3] = 32'h0000_0FF0;
    v_op[4] = AluXor; v_a[4] = 32'h0000_FFFF;  v_b[4] = 32'h0000_00FF;  v_res[4] = 32'h0000_FF00;
    v_op[5] = AluSll; v_a[5] = 32'd1;          v_b[5] = 32'd4;          v_res[5] = 32'd16;
    v_op[6] = AluSrl; v_a[6] = 32'h8000_0000;  v_b[6] = 32'd31;         v_res[6] = 32'd1;
    v_op[7] = AluSlt; v_a[7] = 32'hFFFF_FFFF;  v_b[7] = 32'd1;          v_res[7] = 32'd1;

    reset      = 1'b0;
    flush      = 1'b0;
    in_ready   = 1'b0;
    in_mop     = mk(0);
    out_accept = 1'b0;
`ifdef ALU_EXEC_PIPE_PERF_EN
    perf_clr   = 1'b0;
`endif

    // Reset state
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_out_ready", 64'(out_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Reset with two ops in flight
    out_accept = 1'b1;
    in_ready   = 1'b1;
    in_mop     = mk(0);
    cyc();
    in_mop = mk(1);
    cyc();
    in_ready = 1'b0;
    cyc();
    check("mid_occ_before", 64'(occupancy), 64'd2);
    reset = 1'b0;
    #1;
    check("mid_rst_async_occ", 64'(occupancy), 64'd0);
    cyc();
    reset = 1'b1;
    #1;
    check("mid_rst_out_ready", 64'(out_ready), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (6) begin
      cyc();
      if (out_ready) seen++;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);

    // Streaming: 8 back-to-back ops, out_accept held high
    first_k   = -1;
    got       = 0;
    busy_seen = 0;
    for (int k = 0; k < 11; k++) begin
      in_ready = (k < 8);
      in_mop   = mk((k < 8) ? k : 0);
      #1;
      if (busy) busy_seen++;
      cyc();
      if (out_ready) begin
        if (first_k < 0) first_k = k;
        if (got < 8) check("stream_out", got_of(out_mop), exp_of(got));
        got++;
      end
    end
    in_ready = 1'b0;
    check("stream_latency", 64'(first_k), 64'd3);
    check("stream_count", 64'(got), 64'd8);
    check("stream_busy", 64'(busy_seen), 64'd0);
    cyc();
    check("stream_drained_occ", 64'(occupancy), 64'd0);

    // Backpressure: 6 cycles of continuous feed with out_accept low
    out_accept = 1'b0;
    idx        = 0;
    for (int k = 0; k < 6; k++) begin
      in_ready = 1'b1;
      in_mop   = mk(idx);
      #1;
      check("bp_busy", 64'(busy), 64'(k >= 4));
      fired = !busy;
      cyc();
      if (fired) idx++;
      check("bp_occ", 64'(occupancy), 64'((k < 4) ? k + 1 : 4));
      if (k >= 3) check("bp_hold", got_of(out_mop), exp_of(0));
    end
    check("bp_accepted", 64'(idx), 64'd4);
    in_ready   = 1'b0;
    out_accept = 1'b1;
    got        = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_ready) begin
        if (got < 4) check("bp_drain", got_of(out_mop), exp_of(got));
        got++;
      end
      cyc();
    end
    check("bp_drain_count", 64'(got), 64'd4);
    check("bp_drain_occ", 64'(occupancy), 64'd0);

    // Bubble collapse: one op stalled at the tail, three empty stages ahead
    out_accept = 1'b0;
    in_ready   = 1'b1;
    in_mop     = mk(0);
    cyc();
    in_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    check("bub_occ1", 64'(occupancy), 64'd1);
    check("bub_tail_valid", 64'(out_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      in_ready = 1'b1;
      in_mop   = mk(k + 1);
      #1;
      check("bub_busy", 64'(busy), 64'd0);
      cyc();
    end
    check("bub_occ4", 64'(occupancy), 64'd4);
    check("bub_tail_hold", got_of(out_mop), exp_of(0));

    // Flush on a full pipe with in_ready and out_accept both high
    in_ready   = 1'b1;
    in_mop     = mk(4);
    out_accept = 1'b1;
    flush      = 1'b1;
    #1;
    check("fl_busy", 64'(busy), 64'd1);
    check("fl_out_valid", 64'(out_ready), 64'd1);
    check("fl_out_mop", got_of(out_mop), exp_of(0));
    cyc();
    flush    = 1'b0;
    in_ready = 1'b0;
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_out_ready", 64'(out_ready), 64'd0);
    seen = 0;
    repeat (6) begin
      cyc();
      if (out_ready) seen++;
    end
    check("fl_no_output", 64'(seen), 64'd0);

    // Full pipe: accept at the tail and fire at the head in the same cycle
    out_accept = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_ready = 1'b1;
      in_mop   = mk(k);
      cyc();
    end
    check("sim_full_occ", 64'(occupancy), 64'd4);
    in_ready   = 1'b1;
    in_mop     = mk(4);
    out_accept = 1'b1;
    #1;
    check("sim_busy", 64'(busy), 64'd0);
    cyc();
    in_ready = 1'b0;
    check("sim_occ", 64'(occupancy), 64'd4);
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_ready) begin
        if (got < 4) check("sim_drain", got_of(out_mop), exp_of(got + 1));
        got++;
      end
      cyc();
    end
    check("sim_drain_count", 64'(got), 64'd4);

`ifdef ALU_EXEC_PIPE_PERF_EN
    // Perf counters: 5 fires and 3 stalled cycles, then clear against a fire
    perf_clr = 1'b1;
    in_ready = 1'b0;
    cyc();
    perf_clr = 1'b0;
    check("perf_clr_issued", 64'(perf_issued), 64'd0);
    check("perf_clr_stall", 64'(perf_stall), 64'd0);
    for (int k = 0; k < 8; k++) begin
      out_accept = (k == 7);
      in_ready   = 1'b1;
      in_mop     = mk((k < 4) ? k : 4);
      cyc();
    end
    in_ready = 1'b0;
    check("perf_issued", 64'(perf_issued), 64'd5);
    check("perf_stall", 64'(perf_stall), 64'd3);
    perf_clr   = 1'b1;
    in_ready   = 1'b1;
    in_mop     = mk(5);
    out_accept = 1'b1;
    #1;
    check("perf_clr_fire_busy", 64'(busy), 64'd0);
    cyc();
    perf_clr = 1'b0;
    in_ready = 1'b0;
    check("perf_clr_win_issued", 64'(perf_issued), 64'd0);
    check("perf_clr_win_stall", 64'(perf_stall), 64'd0);
    repeat (8) cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Parametrised ALU execution pipeline. Successor to the fixed two-stage ALU pipe.
- Sits between the issue stage and writeback. Accepts one micro_op_t per cycle and applies ALU::alu at a configurable stage.
- Delivers results with valid/accept backpressure and per-stage bubble collapsing.
- Supports synchronous flush and real busy reporting.

Parameters:
- STAGES, 2, number of register stages (min 2); unstalled latency in cycles.
- ALU_STAGE, 1, index of the stage whose load applies ALU::alu (1..STAGES-1).
- OCC_W, $clog2(STAGES+1), width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous kill of all in-flight ops.
- in_ready  in  1  upstream op valid.
- in_mop  in  micro_op_t  upstream op.
- busy  out  1  pipe cannot accept this cycle.
- out_ready  out  1  result valid.
- out_mop  out  micro_op_t  result op.
- out_accept  in  1  downstream takes out_mop this cycle.
- occupancy  out  OCC_W  count of valid stages.

Behaviour:
- Stages 0..STAGES-1, each holding {valid, mop}. Only valid bits are reset; mop registers are not reset.
- Reset (reset=0, async): all valid bits 0. Then out_ready=0, occupancy=0, busy=0. out_mop is don't-care while out_ready=0. Reset mid-stream discards all ops, with no partial results.
- adv[S-1] = !valid[S-1] | out_accept.
- adv[i] = !valid[i] | adv[i+1], for i < S-1. This collapses bubbles: a stalled tail does not block empty earlier stages.
- busy = flush | !adv[0]. It is combinational; the upstream must hold the op while busy=1.
- Accept: fire = in_ready & !busy. On fire, stage 0 loads in_mop and valid[0]=1. If adv[0] and !fire, valid[0] is cleared.
- Stage i>0: when adv[i], it loads stage i-1 contents (valid included).
  - If i == ALU_STAGE, the loaded mop is ALU::alu(stage[i-1].mop). Otherwise it is a plain copy.
  - ALU::alu is evaluated only when stage[i-1].valid=1.
- out_ready = valid[S-1]; out_mop = stage[S-1].mop. The output must hold stable while out_ready & !out_accept.
- Latency: op accepted at edge N is out_ready after edge N+STAGES-1 (the (STAGES-1)-th edge after acceptance) with out_accept held 1. This matches legacy two-cycle timing at STAGES=2.
- Throughput: 1 op/cycle with out_accept=1. Full pipe with out_accept=0 for one cycle gives busy=1 that cycle, no loss and no duplication.
- Simultaneous accept at the output and fire at the input when full: both proceed and the pipe stays full.
- flush=1 at an edge: all valid bits are cleared and in_ready that cycle is ignored (busy=1). out_accept that cycle is still a valid handshake for the current out_mop. Flush takes priority over stage advance.
- occupancy = popcount(valid). It is registered, consistent with the valid bits after each edge, and 0 after reset or flush.
- Order is strictly preserved. No op is ever duplicated or dropped except by flush or reset.
- Elaboration check: fatal error if STAGES<2 or ALU_STAGE is not in 1..STAGES-1.

Optional Feature:
- Macro: ALU_EXEC_PIPE_PERF_EN.
- Defined: adds ports perf_issued (out, 32), perf_stall (out, 32) and perf_clr (in, 1).
  - perf_issued increments on each fire.
  - perf_stall increments on each cycle with in_ready & busy & !flush.
  - Both wrap at 2^32, clear on reset and on perf_clr. perf_clr wins over increment in the same cycle.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package ExecPipeTypes (imports DecoderTypes):
  - exec_stage_t struct {logic valid; micro_op_t mop}.
  - Default constants EXEC_STAGES_DEF=2 and EXEC_ALU_STAGE_DEF=1.
- Sub-module exec_stage_reg: one stage register with async active-low reset of valid, load enable, optional ALU apply (parameter APPLY_ALU). It is instantiated STAGES times in a generate loop.
- Advance chain, busy and occupancy logic live in the top module.

Test Plan:
- Reset: assert reset=0 mid-stream with 2 ops in flight; release -> out_ready=0, occupancy=0, busy=0, no output ever appears for those ops.
- Streaming: STAGES=4, ALU_STAGE=2, out_accept=1, 8 back-to-back ops -> first result exactly 3 edges after first fire, 8 consecutive out_ready cycles, each out_mop == ALU::alu(input), in order.
- Backpressure: STAGES=4, out_accept=0 for 6 cycles while feeding continuously -> busy asserts once occupancy=4, out_mop stable throughout; on release all ops drain in order with none lost.
- Bubble collapse: one op stalled at the output, stages 0..2 empty, in_ready=1 for 3 cycles -> all 3 accepted (busy=0), occupancy reaches 4.
- Flush: full pipe, flush=1 with in_ready=1 and out_accept=1 -> busy=1, current out_mop counted as delivered, next cycle occupancy=0, out_ready=0, the flush-cycle input never emerges.
- Perf (ALU_EXEC_PIPE_PERF_EN): 5 fires plus 3 stalled cycles -> perf_issued=5, perf_stall=3; perf_clr with simultaneous fire -> both 0 next cycle.
